// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and link constants common to both ends.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 50;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_receiver_if.sv
// Byte-side and pin-side signals of the UART receiver, bundled for the consumer.
// Handshake: RxFull acts as valid and stays high with RxData stable until the consumer
// pulses RxRead for one cycle; the byte is consumed on that edge and RxFull drops next cycle.
interface uart_rx_receiver_if;
  import uart_pkg::*;

  logic                      RxLine;
  logic                      RxRead;
  logic [UART_DATA_BITS-1:0] RxData;
  logic                      RxFull;
  logic                      FrameErr;
  logic                      Overrun;
  logic                      RxBusy;
  rx_state_t                 dbg_state;

  modport master (
    output RxLine, RxRead,
    input  RxData, RxFull, FrameErr, Overrun, RxBusy, dbg_state
  );

  modport slave (
    input  RxLine, RxRead,
    output RxData, RxFull, FrameErr, Overrun, RxBusy, dbg_state
  );
endinterface

// File: rtl/uart_rx_receiver_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM plus a one-byte holding register with
// framing-error and overrun flags.
module uart_rx_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                Enable,
  input  logic                Reset,
  uart_rx_receiver_if.slave   rx
);
  localparam int DATA_BITS = UART_DATA_BITS;
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx_receiver: CLKS_PER_BIT must be >= 4");
  end

  logic rx_s;

  sync_2ff u_sync (
    .clk (Enable),
    .rst (Reset),
    .d   (rx.RxLine),
    .q   (rx_s)
  );

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 good_n, ferr_set;
  logic                 load_pend;

  logic [DATA_BITS-1:0] data_q;
  logic                 full_q, ferr_q, ovr_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    good_n   = 1'b0;
    ferr_set = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        // Half a bit after the edge: a high line here means it was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = RX_DATA;
            idx_n   = '0;
          end else begin
            state_n = RX_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n          = '0;
          shreg_n[idx]   = rx_s;
          if (idx == IDX_LAST) state_n = RX_STOP;
          else                 idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = RX_IDLE;
            good_n  = 1'b1;
          end else begin
            state_n  = RX_WAIT_IDLE;
            ferr_set = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge Enable) begin
    if (Reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      load_pend <= 1'b0;
      data_q    <= '0;
      full_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      load_pend <= good_n;

      if (rx.RxRead) begin
        ferr_q <= 1'b0;
        if (full_q) begin
          full_q <= 1'b0;
          ovr_q  <= 1'b0;
        end
      end

      // A read in the same cycle as the load frees the slot, so the new byte is kept.
      if (load_pend) begin
        if (!full_q || rx.RxRead) begin
          data_q <= shreg;
          full_q <= 1'b1;
          ferr_q <= 1'b0;
          ovr_q  <= 1'b0;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      if (ferr_set) ferr_q <= 1'b1;
    end
  end

  assign rx.RxData    = data_q;
  assign rx.RxFull    = full_q;
  assign rx.FrameErr  = ferr_q;
  assign rx.Overrun   = ovr_q;
  assign rx.RxBusy    = (state != RX_IDLE);
  assign rx.dbg_state = state;
endmodule

// File: tb/tb_uart_rx_receiver.sv
// Directed bench for uart_rx_receiver: 8N1 frames at 50 clocks per bit, checked against hand values.
module tb_uart_rx_receiver;
  import uart_pkg::*;

  localparam int CPB = 50;

  logic Enable = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t_start = 0;
  int   lat;
  bit   ok;
  logic [7:0] exp_q[$];
  logic [7:0] rom [5] = '{8'h55, 8'h41, 8'h52, 8'h54, 8'h21};

  uart_rx_receiver_if bus ();

  uart_rx_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .Enable (Enable),
    .Reset  (Reset),
    .rx     (bus)
  );

  // clock / reset
  always #5 Enable = ~Enable;
  always @(posedge Enable) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // drivers (all called and returning on a negedge)
  task automatic drive_level(input logic v, input int n);
    bus.RxLine = v;
    repeat (n) @(negedge Enable);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    t_start = cyc + 1;
    drive_level(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_level(b[i], CPB);
    drive_level(stop, CPB);
  endtask

  task automatic read_byte();
    @(negedge Enable);
    bus.RxRead = 1'b1;
    @(negedge Enable);
    bus.RxRead = 1'b0;
  endtask

  task automatic wait_full(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge Enable);
      #1;
      if (bus.RxFull) found = 1'b1;
    end
    if (!found) check("wait_full", 32'd0, 32'd1);
  endtask

  task automatic recv_check(input logic [7:0] b, input string tag);
    fork
      send_frame(b, 1'b1);
      wait_full(700, ok);
    join
    check(tag, 32'(bus.RxData), 32'(b));
    check({tag, "_ferr"}, 32'(bus.FrameErr), 32'd0);
  endtask

  // scoreboard side of the multi-byte stream
  task automatic loop_consumer(input int n);
    for (int i = 0; i < n; i++) begin
      wait_full(700, ok);
      if (ok) check("loop_byte", 32'(bus.RxData), 32'(exp_q.pop_front()));
      read_byte();
    end
  endtask

  initial begin
    int rise, fall;
    logic [7:0] pat;

    Reset      = 1'b1;
    bus.RxLine = 1'b1;
    bus.RxRead = 1'b0;
    repeat (5) @(posedge Enable);
    #1;
    check("rst_data", 32'(bus.RxData), 32'h00);
    check("rst_full", 32'(bus.RxFull), 32'd0);
    check("rst_ferr", 32'(bus.FrameErr), 32'd0);
    check("rst_ovr", 32'(bus.Overrun), 32'd0);
    check("rst_busy", 32'(bus.RxBusy), 32'd0);
    @(negedge Enable);
    Reset = 1'b0;
    repeat (3) @(negedge Enable);

    // 0x41 with latency measured from the posedge that first samples the start bit
    fork
      send_frame(8'h41, 1'b1);
      begin
        wait_full(600, ok);
        lat = cyc - t_start;
      end
    join
    check("lat_41", 32'(lat), 32'd478);
    check("data_41", 32'(bus.RxData), 32'h41);
    read_byte();
    check("read_41_full", 32'(bus.RxFull), 32'd0);

    // 10-cycle low glitch
    rise = -1;
    fall = -1;
    fork
      begin
        t_start = cyc + 1;
        drive_level(1'b0, 10);
        drive_level(1'b1, 40);
      end
      repeat (45) begin
        @(posedge Enable);
        #1;
        if (bus.RxBusy && rise < 0) rise = cyc - t_start;
        if (!bus.RxBusy && rise >= 0 && fall < 0) fall = cyc - t_start;
      end
    join
    check("glitch_rise", 32'(rise), 32'd2);
    check("glitch_fall", 32'(fall), 32'd27);
    check("glitch_full", 32'(bus.RxFull), 32'd0);

    // 0x55 with stop bit 0, line held low afterwards
    send_frame(8'h55, 1'b0);
    drive_level(1'b0, 200);
    check("ferr_set", 32'(bus.FrameErr), 32'd1);
    check("ferr_full", 32'(bus.RxFull), 32'd0);
    check("ferr_state", 32'(bus.dbg_state), 32'(RX_WAIT_IDLE));
    check("ferr_busy", 32'(bus.RxBusy), 32'd1);
    drive_level(1'b1, 5);
    check("ferr_idle", 32'(bus.dbg_state), 32'(RX_IDLE));
    check("ferr_hold", 32'(bus.FrameErr), 32'd1);
    recv_check(8'h33, "data_33");
    read_byte();

    // back-to-back without a read: second byte dropped
    send_frame(8'h48, 1'b1);
    check("b2b_ovr0", 32'(bus.Overrun), 32'd0);
    send_frame(8'h49, 1'b1);
    repeat (2) @(negedge Enable);
    check("b2b_data", 32'(bus.RxData), 32'h48);
    check("b2b_full", 32'(bus.RxFull), 32'd1);
    check("b2b_ovr", 32'(bus.Overrun), 32'd1);
    read_byte();
    check("b2b_rd_full", 32'(bus.RxFull), 32'd0);
    check("b2b_rd_ovr", 32'(bus.Overrun), 32'd0);

    // read while empty does nothing to data
    read_byte();
    check("empty_rd_data", 32'(bus.RxData), 32'h48);

    // reset in the middle of data bit 4 of 0xA5, with a byte still held
    send_frame(8'h11, 1'b1);
    check("pre_rst_full", 32'(bus.RxFull), 32'd1);
    pat = 8'hA5;
    drive_level(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_level(pat[i], CPB);
    drive_level(pat[4], CPB / 2);
    check("mid_state", 32'(bus.dbg_state), 32'(RX_DATA));
    Reset      = 1'b1;
    bus.RxLine = 1'b1;
    @(negedge Enable);
    Reset = 1'b0;
    check("mid_rst_data", 32'(bus.RxData), 32'h00);
    check("mid_rst_full", 32'(bus.RxFull), 32'd0);
    check("mid_rst_ferr", 32'(bus.FrameErr), 32'd0);
    check("mid_rst_ovr", 32'(bus.Overrun), 32'd0);
    check("mid_rst_busy", 32'(bus.RxBusy), 32'd0);
    repeat (3) @(negedge Enable);
    recv_check(8'h5A, "data_5a");
    read_byte();

    // stream of bytes through the expected queue
    foreach (rom[i]) exp_q.push_back(rom[i]);
    fork
      foreach (rom[i]) send_frame(rom[i], 1'b1);
      loop_consumer(5);
    join
    check("loop_left", 32'(exp_q.size()), 32'd0);
    check("loop_ovr", 32'(bus.Overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
